muller_c_hs_driver: RTL and testbench

- Clocked 4-phase handshake driver that sits directly upstream of the N-input Muller C-element.
- Drives the element's N inputs and synchronizes its output back into the clock domain as the acknowledge.
- Runs a programmed number of full return-to-zero handshakes and counts the completed ones.
- Flags premature or missing C-element transitions, giving the team a self-checking on-chip exerciser for the async cell.

---
 rtl/muller_c_hs_driver.sv | 243 ++++++++++++++++++++++++
 tb/tb_muller_c_hs_driver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muller_c_hs_driver.sv
`default_nettype none
// ============================================================================
// Module      : muller_c_hs_driver
// Description : Clocked 4-phase return-to-zero handshake driver for an
//               N-input Muller C-element. Drives the element inputs, pulls
//               its output back through a synchronizer as the acknowledge,
//               counts completed handshakes and flags premature or missing
//               element transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module muller_c_hs_driver #(
  parameter int N           = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  input  logic             stagger,
  input  logic [TO_W-1:0]  timeout,
  input  logic             c_out,
  output logic [N-1:0]     io_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] hs_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RISE    = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_FALL    = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  localparam logic [N-1:0] C_ALL_ONES = {N{1'b1}};

  logic [2:0]             state_q, state_d;
  logic [N-1:0]           io_in_q, io_in_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TO_W-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]       hs_q, hs_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cyc_q, cyc_d;
  logic                   stag_q, stag_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic                   zdone_q, zdone_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic                   c_sync;
  logic [N-1:0]           bit_mask;
  logic [CNT_W-1:0]       hs_inc;
  logic                   to_hit;
  logic                   last_bit;

  assign c_sync   = sync_q[SYNC_STAGES-1];
  assign bit_mask = N'(1) << idx_q;
  assign hs_inc   = hs_q + CNT_W'(1);
  assign to_hit   = (to_q != '0) && (timer_q == (to_q - TO_W'(1)));
  assign last_bit = (idx_q == IDX_W'(N - 1));

  // Bring the asynchronous C-element output into the clock domain.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], c_out};
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake datapath registers; reset drops the element inputs at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      io_in_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      hs_q    <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      stag_q  <= 1'b0;
      to_q    <= '0;
      zdone_q <= 1'b0;
    end else begin
      io_in_q <= io_in_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      hs_q    <= hs_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stag_q  <= stag_d;
      to_q    <= to_d;
      zdone_q <= zdone_d;
    end
  end

  // Next-state and datapath update for the four handshake phases.
  always_comb begin
    state_d = state_q;
    io_in_d = io_in_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    hs_d    = hs_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    stag_d  = stag_q;
    to_d    = to_q;
    zdone_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        io_in_d = '0;
        if (start) begin
          hs_d  = '0;
          err_d = 1'b0;
          if (cycles != '0) begin
            cyc_d   = cycles;
            stag_d  = stagger;
            to_d    = timeout;
            idx_d   = '0;
            timer_d = '0;
            state_d = S_RISE;
          end else begin
            // Empty run: report completion without touching the element.
            zdone_d = 1'b1;
          end
        end
      end

      S_RISE: begin
        // Element must not fire until every input is high.
        if (c_sync && (io_in_q != C_ALL_ONES)) begin
          err_d   = 1'b1;
          io_in_d = '0;
          state_d = S_ERR;
        end else if (!stag_q) begin
          io_in_d = C_ALL_ONES;
          timer_d = '0;
          state_d = S_WAIT_HI;
        end else begin
          io_in_d = io_in_q | bit_mask;
          if (last_bit) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = S_WAIT_HI;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_WAIT_HI: begin
        if (c_sync) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = S_FALL;
        end else if (to_hit) begin
          err_d   = 1'b1;
          io_in_d = '0;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end

      S_FALL: begin
        // Element must hold high until every input is low.
        if (!c_sync && (io_in_q != '0)) begin
          err_d   = 1'b1;
          io_in_d = '0;
          state_d = S_ERR;
        end else if (!stag_q) begin
          io_in_d = '0;
          timer_d = '0;
          state_d = S_WAIT_LO;
        end else begin
          io_in_d = io_in_q & ~bit_mask;
          if (last_bit) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = S_WAIT_LO;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_WAIT_LO: begin
        if (!c_sync) begin
          hs_d    = hs_inc;
          timer_d = '0;
          idx_d   = '0;
          state_d = (hs_inc == cyc_q) ? S_DONE : S_RISE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          io_in_d = '0;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        io_in_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        io_in_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE) || (state_q == S_ERR) || zdone_q;
  end

  assign io_in    = io_in_q;
  assign error    = err_q;
  assign hs_count = hs_q;

endmodule
`default_nettype wire

// File: tb/tb_muller_c_hs_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_muller_c_hs_driver
// Description : Directed bench for muller_c_hs_driver with a behavioural
//               C-element (ideal, stuck-low or OR-gate fault).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muller_c_hs_driver;

  localparam int N  = 6;
  localparam int SS = 2;
  localparam int CW = 16;
  localparam int TW = 8;
  localparam logic [N-1:0] ALL1 = {N{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cycles = '0;
  logic          stagger = 1'b0;
  logic [TW-1:0] timeout = '0;
  logic          c_out;
  logic [N-1:0]  io_in;
  logic          busy, done, error;
  logic [CW-1:0] hs_count;

  // 0: ideal C-element, 1: output stuck low, 2: OR gate
  int   mode = 0;
  logic c_state = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] tr[$];

  muller_c_hs_driver #(.N(N), .SYNC_STAGES(SS), .CNT_W(CW), .TO_W(TW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .cycles   (cycles),
    .stagger  (stagger),
    .timeout  (timeout),
    .c_out    (c_out),
    .io_in    (io_in),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .hs_count (hs_count)
  );

  always #5 clk = ~clk;

  // Behavioural C-element: follows unanimous inputs, otherwise holds.
  always @(io_in) begin
    if (io_in == ALL1) c_state = 1'b1;
    else if (io_in == '0) c_state = 1'b0;
  end

  assign c_out = (mode == 0) ? c_state : (mode == 1) ? 1'b0 : (|io_in);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one run and follow it until done, recording the io_in trace.
  task automatic run_hs(input int cyc, input int stg, input int to, input int md,
                        output int hs, output int err, output int rises,
                        output int dones, output int hi);
    logic [N-1:0] last;
    mode    = md;
    cycles  = CW'(cyc);
    stagger = stg[0];
    timeout = TW'(to);
    start   = 1'b1;
    tick;
    start   = 1'b0;
    chk("accept_busy", int'(busy), 1);
    chk("accept_err_clear", int'(error), 0);
    tr.delete();
    last  = '0;
    rises = 0;
    dones = 0;
    hi    = 0;
    for (int k = 0; k < 3000 && dones == 0; k++) begin
      if (io_in != last) begin
        tr.push_back(io_in);
        if (io_in == ALL1) rises++;
        last = io_in;
      end
      if (io_in == ALL1) hi++;
      if (done) dones++;
      else tick;
    end
    if (dones == 0) chk("run_budget", 0, 1);
    hs  = int'(hs_count);
    err = int'(error);
    chk("done_io_in_zero", int'(io_in), 0);
    tick;
    if (done) dones++;
    chk("idle_busy_low", int'(busy), 0);
  endtask

  typedef struct {
    int cyc;
    int stg;
    int to;
    int md;
    int e_hs;
    int e_err;
    int e_rises;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, err, rises, dones, hi;
    logic [N-1:0] exp_tr[12];

    vt[0] = '{3, 0, 0,  0, 3, 0, 3};  // ideal, parallel, three handshakes
    vt[1] = '{1, 1, 0,  0, 1, 0, 1};  // ideal, staggered, single handshake
    vt[2] = '{2, 0, 10, 1, 0, 1, 1};  // stuck-low element, timeout
    vt[3] = '{2, 1, 0,  2, 0, 1, 0};  // OR-gate element fires early
    vt[4] = '{4, 1, 20, 0, 4, 0, 4};  // ideal, staggered, generous timeout
    vt[5] = '{2, 0, 3,  0, 2, 0, 2};  // ack arrives on the last allowed clock
    vt[6] = '{2, 0, 2,  0, 0, 1, 1};  // timeout one clock before the ack

    exp_tr = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F,
               6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    chk("rst_io_in", int'(io_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_hs_count", int'(hs_count), 0);

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      run_hs(vt[i].cyc, vt[i].stg, vt[i].to, vt[i].md, hs, err, rises, dones, hi);
      chk($sformatf("v%0d_hs_count", i), hs, vt[i].e_hs);
      chk($sformatf("v%0d_error", i), err, vt[i].e_err);
      chk($sformatf("v%0d_rises", i), rises, vt[i].e_rises);
      chk($sformatf("v%0d_done_pulses", i), dones, 1);
      tick;
    end

    // Timeout lands exactly 10 clocks after entering WAIT_HI
    run_hs(2, 0, 10, 1, hs, err, rises, dones, hi);
    chk("to10_hi_cycles", hi, 10);
    chk("to10_error", err, 1);
    tick;

    // Staggered single handshake: bit-by-bit rise then fall, bit 0 first
    run_hs(1, 1, 0, 0, hs, err, rises, dones, hi);
    chk("stag_trace_len", tr.size(), 12);
    for (int i = 0; i < 12 && i < tr.size(); i++)
      chk($sformatf("stag_trace_%0d", i), int'(tr[i]), int'(exp_tr[i]));
    tick;

    // Start with cycles==0: done next cycle, never busy, inputs untouched
    mode    = 0;
    cycles  = '0;
    stagger = 1'b0;
    timeout = '0;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_io_in", int'(io_in), 0);
    chk("zero_hs", int'(hs_count), 0);
    tick;
    chk("zero_done_drop", int'(done), 0);
    chk("zero_busy_after", int'(busy), 0);

    // Start while busy is ignored
    mode    = 0;
    cycles  = CW'(5);
    stagger = 1'b0;
    timeout = '0;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    repeat (10) tick;
    cycles  = CW'(2);
    stagger = 1'b1;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    chk("ignore_busy", int'(busy), 1);
    dones = 0;
    for (int k = 0; k < 3000 && dones == 0; k++) begin
      if (done) dones++;
      else tick;
    end
    chk("ignore_done_seen", dones, 1);
    chk("ignore_hs_count", int'(hs_count), 5);
    chk("ignore_error", int'(error), 0);
    tick;
    chk("ignore_done_drop", int'(done), 0);
    tick;

    // Asynchronous reset during WAIT_HI
    mode    = 1;
    cycles  = CW'(3);
    stagger = 1'b0;
    timeout = '0;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    for (int k = 0; k < 20 && io_in != ALL1; k++) tick;
    chk("mid_reached_hi", int'(io_in), int'(ALL1));
    repeat (3) tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_io_in", int'(io_in), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_error", int'(error), 0);
    chk("mid_rst_hs", int'(hs_count), 0);
    tick;
    rst = 1'b0;
    tick;
    run_hs(2, 0, 0, 0, hs, err, rises, dones, hi);
    chk("post_rst_hs", hs, 2);
    chk("post_rst_error", err, 0);
    chk("post_rst_dones", dones, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
